// File: rtl/microondas_pkg.sv
// Shared constants for the microwave sequencing controller: FSM encodings and keypad limits.
package microondas_pkg;

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StEntry = 3'd1;
    localparam logic [2:0] StCook  = 3'd2;
    localparam logic [2:0] StPause = 3'd3;
    localparam logic [2:0] StDone  = 3'd4;

    localparam int unsigned MaxDigitsDefault = 3;
    localparam logic [3:0]  BcdMax           = 4'd9;

    function automatic logic is_bcd(input logic [3:0] digit);
        return digit <= BcdMax;
    endfunction

endpackage

// File: rtl/prescaler_tick.sv
// Modulo-N prescaler: one-cycle tick on the wrap, count held while disabled, synchronous clear.
module prescaler_tick #(
    parameter int unsigned MODULUS = 100
) (
    input  logic clk,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam int unsigned    CntW   = (MODULUS > 1) ? $clog2(MODULUS) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(MODULUS - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == CntMax) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/microondas_ctrl.sv
// Microwave sequencing controller: keypad digit loading, 1 Hz count enable, magnetron and done
// control around an external 3-digit BCD countdown timer.
module microondas_ctrl
    import microondas_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 100,
    parameter int unsigned MAX_DIGITS    = MaxDigitsDefault,
    parameter int unsigned DONE_SECS     = 2
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       startn,
    input  logic       stopn,
    input  logic       door_closed,
    input  logic       timer_zero,
    output logic [3:0] timer_data,
    output logic       timer_loadn,
    output logic       timer_en,
    output logic       timer_clearn,
    output logic       mag_on,
    output logic       done,
    output logic [2:0] state_o
);

    localparam int unsigned      DoneCycles = DONE_SECS * TICKS_PER_SEC;
    localparam int unsigned      DoneW      = (DoneCycles > 1) ? $clog2(DoneCycles) : 1;
    localparam int unsigned      CntW       = $clog2(MAX_DIGITS + 1);
    localparam logic [CntW-1:0]  CntMax     = CntW'(MAX_DIGITS);
    localparam logic [DoneW-1:0] DoneLast   = DoneW'(DoneCycles - 1);

    logic [2:0]       state_q, state_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [DoneW-1:0] done_cnt_q, done_cnt_d;
    logic [3:0]       data_q, data_d;
    logic             loadn_q, loadn_d;
    logic             clearn_q, clearn_d;
    logic             en_q, en_d;
    logic             mag_q, mag_d;
    logic             done_q, done_d;
    logic             pres_clear, pres_en, pres_tick;
    logic             key_ok;

    assign key_ok = key_valid && is_bcd(key_digit);

    prescaler_tick #(
        .MODULUS(TICKS_PER_SEC)
    ) u_prescaler (
        .clk  (clk),
        .clear(clear | pres_clear),
        .en   (pres_en),
        .tick (pres_tick)
    );

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        done_cnt_d = done_cnt_q;
        data_d     = data_q;
        loadn_d    = 1'b1;
        clearn_d   = 1'b1;
        pres_clear = 1'b0;
        pres_en    = 1'b0;
        case (state_q)
            StIdle: begin
                if (key_ok) begin
                    data_d  = key_digit;
                    loadn_d = 1'b0;
                    count_d = CntW'(1);
                    state_d = StEntry;
                end
            end
            StEntry: begin
                // Stop beats start, and a start request swallows any coincident key.
                if (!stopn) begin
                    clearn_d = 1'b0;
                    count_d  = '0;
                    state_d  = StIdle;
                end else if (!startn) begin
                    if (door_closed && !timer_zero) begin
                        pres_clear = 1'b1;
                        state_d    = StCook;
                    end
                end else if (key_ok && count_q < CntMax) begin
                    data_d  = key_digit;
                    loadn_d = 1'b0;
                    count_d = count_q + 1'b1;
                end
            end
            StCook: begin
                if (timer_zero) begin
                    done_cnt_d = '0;
                    state_d    = StDone;
                end else if (!door_closed || !stopn) begin
                    state_d = StPause;
                end else begin
                    pres_en = 1'b1;
                end
            end
            StPause: begin
                if (!stopn) begin
                    clearn_d = 1'b0;
                    count_d  = '0;
                    state_d  = StIdle;
                end else if (!startn && door_closed) begin
                    // The resume cycle itself counts as cooking time.
                    pres_en = 1'b1;
                    state_d = StCook;
                end
            end
            StDone: begin
                if (!stopn || done_cnt_q == DoneLast) begin
                    count_d = '0;
                    state_d = StIdle;
                end else begin
                    done_cnt_d = done_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        en_d   = pres_tick;
        mag_d  = (state_d == StCook);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q    <= StIdle;
            count_q    <= '0;
            done_cnt_q <= '0;
            data_q     <= '0;
            loadn_q    <= 1'b1;
            clearn_q   <= 1'b0;
            en_q       <= 1'b0;
            mag_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            done_cnt_q <= done_cnt_d;
            data_q     <= data_d;
            loadn_q    <= loadn_d;
            clearn_q   <= clearn_d;
            en_q       <= en_d;
            mag_q      <= mag_d;
            done_q     <= done_d;
        end
    end

    assign timer_data   = data_q;
    assign timer_loadn  = loadn_q;
    assign timer_en     = en_q;
    assign timer_clearn = clearn_q;
    assign mag_on       = mag_q;
    assign done         = done_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_microondas_ctrl.sv
// Scenario bench for microondas_ctrl with a behavioural mm:ss countdown timer model attached.
module tb_microondas_ctrl;

    localparam int TPS = 100;
    localparam int S_IDLE = 0, S_ENTRY = 1, S_COOK = 2, S_PAUSE = 3, S_DONE = 4;

    logic       clk = 1'b0;
    logic       clear, key_valid, startn, stopn, door_closed, timer_zero;
    logic [3:0] key_digit, timer_data;
    logic       timer_loadn, timer_en, timer_clearn, mag_on, done;
    logic [2:0] state_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Timer model: digits shift in mins<-tens<-ones on load, mm:ss countdown on enable.
    int tm_m = 0, tm_t = 0, tm_o = 0;

    microondas_ctrl #(
        .TICKS_PER_SEC(TPS),
        .MAX_DIGITS   (3),
        .DONE_SECS    (2)
    ) dut (
        .clk         (clk),
        .clear       (clear),
        .key_valid   (key_valid),
        .key_digit   (key_digit),
        .startn      (startn),
        .stopn       (stopn),
        .door_closed (door_closed),
        .timer_zero  (timer_zero),
        .timer_data  (timer_data),
        .timer_loadn (timer_loadn),
        .timer_en    (timer_en),
        .timer_clearn(timer_clearn),
        .mag_on      (mag_on),
        .done        (done),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (timer_clearn === 1'b0) begin
            tm_m <= 0; tm_t <= 0; tm_o <= 0;
        end else if (timer_loadn === 1'b0) begin
            tm_m <= tm_t; tm_t <= tm_o; tm_o <= int'(timer_data);
        end else if (timer_en === 1'b1) begin
            if (tm_o > 0) tm_o <= tm_o - 1;
            else if (tm_t > 0) begin tm_t <= tm_t - 1; tm_o <= 9; end
            else if (tm_m > 0) begin tm_m <= tm_m - 1; tm_t <= 5; tm_o <= 9; end
        end
    end

    assign timer_zero = (tm_m == 0) && (tm_t == 0) && (tm_o == 0);

    function automatic int tm_secs();
        return tm_m * 60 + tm_t * 10 + tm_o;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input int d);
        key_valid = 1'b1;
        key_digit = 4'(d);
        tick();
        key_valid = 1'b0;
    endtask

    task automatic test_reset();
        clear = 1'b1; key_valid = 1'b0; key_digit = 4'd0;
        startn = 1'b1; stopn = 1'b1; door_closed = 1'b1;
        tick(); tick();
        n_tests++;
        if ({state_o, timer_loadn, timer_clearn, timer_en, mag_on, done, timer_data} !==
            {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0}) begin
            n_fail++;
            $display("FAIL reset_vals: st=%0d ld=%b clr=%b en=%b mag=%b dn=%b data=%0d want 0 1 0 0 0 0 0",
                     state_o, timer_loadn, timer_clearn, timer_en, mag_on, done, timer_data);
        end
        clear = 1'b0;
        tick();
        n_tests++;
        if (timer_clearn !== 1'b1) begin
            n_fail++; $display("FAIL reset_release_clearn: got %b want 1", timer_clearn);
        end
    endtask

    task automatic test_entry();
        int digs[3] = '{1, 3, 0};
        for (int i = 0; i < 3; i++) begin
            press(digs[i]);
            n_tests++;
            if (timer_loadn !== 1'b0 || timer_data !== 4'(digs[i])) begin
                n_fail++;
                $display("FAIL entry_load%0d: loadn=%b data=%0d want 0 %0d", i, timer_loadn,
                         timer_data, digs[i]);
            end
            tick();
            n_tests++;
            if (timer_loadn !== 1'b1) begin
                n_fail++; $display("FAIL entry_pulse_width%0d: loadn=%b want 1", i, timer_loadn);
            end
        end
        press(5);
        n_tests++;
        if (timer_loadn !== 1'b1 || state_o !== 3'(S_ENTRY)) begin
            n_fail++;
            $display("FAIL entry_fourth_key: loadn=%b st=%0d want 1 %0d", timer_loadn, state_o,
                     S_ENTRY);
        end
        tick();
        n_tests++;
        if (tm_secs() !== 90) begin
            n_fail++; $display("FAIL entry_timer_value: got %0d s want 90 s", tm_secs());
        end
    endtask

    task automatic test_cook();
        int en_cnt = 0, bad_gap = 0, last = 0, done_at = -1, overlap = 0, dn = 1;
        startn = 1'b0; tick(); startn = 1'b1;
        n_tests++;
        if (mag_on !== 1'b1 || state_o !== 3'(S_COOK)) begin
            n_fail++; $display("FAIL cook_start: mag=%b st=%0d want 1 %0d", mag_on, state_o, S_COOK);
        end
        for (int k = 1; k <= 9500; k++) begin
            tick();
            if (!timer_loadn && timer_en) overlap++;
            if (timer_en) begin
                en_cnt++;
                if (k - last != TPS) bad_gap++;
                last = k;
            end
            if (done) begin done_at = k; break; end
        end
        n_tests++;
        if (en_cnt !== 90 || bad_gap !== 0 || overlap !== 0) begin
            n_fail++;
            $display("FAIL cook_ticks: pulses=%0d bad_gaps=%0d overlaps=%0d want 90 0 0", en_cnt,
                     bad_gap, overlap);
        end
        n_tests++;
        if (done_at !== 9002 || mag_on !== 1'b0 || state_o !== 3'(S_DONE)) begin
            n_fail++;
            $display("FAIL cook_done_entry: at=%0d mag=%b st=%0d want 9002 0 %0d", done_at, mag_on,
                     state_o, S_DONE);
        end
        for (int k = 0; k < 300; k++) begin
            tick();
            if (done) dn++;
            else break;
        end
        n_tests++;
        if (dn !== 2 * TPS || state_o !== 3'(S_IDLE)) begin
            n_fail++;
            $display("FAIL done_duration: cycles=%0d st=%0d want %0d %0d", dn, state_o, 2 * TPS,
                     S_IDLE);
        end
    endtask

    task automatic test_pause_stop();
        int en_cnt = 0, first_en = -1, bad_st = 0;
        press(0); tick(); press(0); tick(); press(5); tick();
        n_tests++;
        if (tm_secs() !== 5) begin
            n_fail++; $display("FAIL pause_load: got %0d s want 5 s", tm_secs());
        end
        startn = 1'b0; tick(); startn = 1'b1;
        for (int k = 1; k <= 249; k++) begin
            tick();
            if (timer_en) en_cnt++;
        end
        n_tests++;
        if (en_cnt !== 2) begin
            n_fail++; $display("FAIL pause_precook_ticks: got %0d want 2", en_cnt);
        end
        door_closed = 1'b0; tick();
        n_tests++;
        if (state_o !== 3'(S_PAUSE) || mag_on !== 1'b0) begin
            n_fail++; $display("FAIL pause_enter: st=%0d mag=%b want %0d 0", state_o, mag_on, S_PAUSE);
        end
        en_cnt = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (timer_en) en_cnt++;
            if (state_o !== 3'(S_PAUSE) || mag_on) bad_st++;
        end
        n_tests++;
        if (en_cnt !== 0 || bad_st !== 0) begin
            n_fail++; $display("FAIL pause_hold: pulses=%0d bad=%0d want 0 0", en_cnt, bad_st);
        end
        door_closed = 1'b1; startn = 1'b0; tick(); startn = 1'b1;
        n_tests++;
        if (state_o !== 3'(S_COOK) || mag_on !== 1'b1) begin
            n_fail++; $display("FAIL pause_resume: st=%0d mag=%b want %0d 1", state_o, mag_on, S_COOK);
        end
        for (int k = 1; k <= 200; k++) begin
            tick();
            if (timer_en) begin first_en = k; break; end
        end
        n_tests++;
        if (first_en !== 50) begin
            n_fail++; $display("FAIL pause_resume_tick: got %0d cycles want 50", first_en);
        end
        tick();
        n_tests++;
        if (tm_secs() !== 2) begin
            n_fail++; $display("FAIL pause_timer_left: got %0d s want 2 s", tm_secs());
        end
        stopn = 1'b0; tick();
        n_tests++;
        if (state_o !== 3'(S_PAUSE) || mag_on !== 1'b0) begin
            n_fail++; $display("FAIL stop_to_pause: st=%0d mag=%b want %0d 0", state_o, mag_on, S_PAUSE);
        end
        startn = 1'b0; tick();
        n_tests++;
        if (state_o !== 3'(S_IDLE) || timer_clearn !== 1'b0 || mag_on !== 1'b0) begin
            n_fail++;
            $display("FAIL pause_start_stop: st=%0d clearn=%b mag=%b want %0d 0 0", state_o,
                     timer_clearn, mag_on, S_IDLE);
        end
        startn = 1'b1; stopn = 1'b1; tick();
        n_tests++;
        if (timer_clearn !== 1'b1 || tm_secs() !== 0) begin
            n_fail++;
            $display("FAIL pause_clear_pulse: clearn=%b secs=%0d want 1 0", timer_clearn, tm_secs());
        end
    endtask

    task automatic test_entry_guard();
        press(0); tick(); press(0); tick(); press(0); tick();
        startn = 1'b0; tick(); tick(); startn = 1'b1;
        n_tests++;
        if (state_o !== 3'(S_ENTRY) || mag_on !== 1'b0) begin
            n_fail++; $display("FAIL guard_zero: st=%0d mag=%b want %0d 0", state_o, mag_on, S_ENTRY);
        end
        stopn = 1'b0; tick(); stopn = 1'b1; tick();
        press(7); tick();
        door_closed = 1'b0; startn = 1'b0; tick(); tick(); startn = 1'b1;
        n_tests++;
        if (state_o !== 3'(S_ENTRY) || mag_on !== 1'b0 || tm_secs() !== 7) begin
            n_fail++;
            $display("FAIL guard_door: st=%0d mag=%b secs=%0d want %0d 0 7", state_o, mag_on,
                     tm_secs(), S_ENTRY);
        end
        door_closed = 1'b1;
        stopn = 1'b0; tick(); stopn = 1'b1; tick();
    endtask

    task automatic test_clear_mid_cook();
        press(2); tick();
        startn = 1'b0; tick(); startn = 1'b1;
        repeat (50) tick();
        clear = 1'b1; tick();
        n_tests++;
        if (state_o !== 3'(S_IDLE) || mag_on !== 1'b0 || timer_clearn !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_mid_cook: st=%0d mag=%b clearn=%b done=%b want 0 0 0 0", state_o,
                     mag_on, timer_clearn, done);
        end
        clear = 1'b0; tick();
        press(4);
        n_tests++;
        if (timer_loadn !== 1'b0 || timer_data !== 4'd4 || state_o !== 3'(S_ENTRY)) begin
            n_fail++;
            $display("FAIL clear_key_after: loadn=%b data=%0d st=%0d want 0 4 %0d", timer_loadn,
                     timer_data, state_o, S_ENTRY);
        end
        tick();
        n_tests++;
        if (tm_secs() !== 4) begin
            n_fail++; $display("FAIL clear_timer_reload: got %0d s want 4 s", tm_secs());
        end
        stopn = 1'b0; tick(); stopn = 1'b1; tick();
    endtask

    task automatic test_random_keys();
        for (int it = 0; it < 6; it++) begin
            int acc[$];
            int n = int'($urandom_range(1, 6));
            int exp_secs;
            for (int j = 0; j < n; j++) begin
                int d = int'($urandom_range(0, 15));
                logic take = (d <= 9) && (acc.size() < 3);
                press(d);
                n_tests++;
                if (take ? (timer_loadn !== 1'b0 || timer_data !== 4'(d)) : (timer_loadn !== 1'b1)) begin
                    n_fail++;
                    $display("FAIL rand_key it%0d k%0d: digit=%0d loadn=%b data=%0d want_load=%b",
                             it, j, d, timer_loadn, timer_data, take);
                end
                if (take) acc.push_back(d);
                repeat ($urandom_range(0, 2)) tick();
            end
            tick();
            exp_secs = 0;
            for (int j = 0; j < acc.size(); j++) begin
                int w = acc.size() - 1 - j;
                exp_secs += acc[j] * ((w == 2) ? 60 : (w == 1) ? 10 : 1);
            end
            n_tests++;
            if (tm_secs() !== exp_secs ||
                state_o !== 3'((acc.size() > 0) ? S_ENTRY : S_IDLE)) begin
                n_fail++;
                $display("FAIL rand_entry it%0d: secs=%0d st=%0d want %0d, %0d digits", it, tm_secs(),
                         state_o, exp_secs, acc.size());
            end
            stopn = 1'b0; tick(); stopn = 1'b1;
            tick();
            n_tests++;
            if (state_o !== 3'(S_IDLE) || tm_secs() !== ((acc.size() > 0) ? 0 : exp_secs)) begin
                n_fail++;
                $display("FAIL rand_cancel it%0d: st=%0d secs=%0d want 0 0", it, state_o, tm_secs());
            end
        end
    endtask

    task automatic test_random_cook();
        for (int it = 0; it < 3; it++) begin
            int d = int'($urandom_range(1, 3));
            int en_cnt = 0, done_at = -1;
            press(d); tick();
            key_valid = 1'b1; key_digit = 4'($urandom_range(0, 9)); startn = 1'b0;
            tick();
            key_valid = 1'b0; startn = 1'b1;
            n_tests++;
            if (state_o !== 3'(S_COOK) || timer_loadn !== 1'b1) begin
                n_fail++;
                $display("FAIL rcook_key_vs_start it%0d: st=%0d loadn=%b want %0d 1", it, state_o,
                         timer_loadn, S_COOK);
            end
            for (int k = 1; k <= 500; k++) begin
                tick();
                if (timer_en) en_cnt++;
                if (done) begin done_at = k; break; end
            end
            n_tests++;
            if (en_cnt !== d || done_at !== d * TPS + 2) begin
                n_fail++;
                $display("FAIL rcook_run it%0d: pulses=%0d done_at=%0d want %0d %0d", it, en_cnt,
                         done_at, d, d * TPS + 2);
            end
            repeat ($urandom_range(0, 150)) tick();
            stopn = 1'b0; tick(); stopn = 1'b1;
            n_tests++;
            if (state_o !== 3'(S_IDLE) || done !== 1'b0) begin
                n_fail++;
                $display("FAIL rcook_stop_done it%0d: st=%0d done=%b want 0 0", it, state_o, done);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_entry();
        test_cook();
        test_pause_stop();
        test_entry_guard();
        test_clear_mid_cook();
        test_random_keys();
        test_random_cook();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/microondas_ctrl.md
Name: microondas_ctrl

Overview:
- Sequencing controller for the microwave's 3-digit countdown timer (mins / sec_tens / sec_ones).
- Captures keypad digits and shifts them into the timer through its active-low load strobe.
- Generates the 1 Hz count-enable tick and gates it by start, stop and door state.
- Drives the magnetron and done indicator, and clears the timer on cancel.

Parameters:
- TICKS_PER_SEC, 100, clk cycles per one timer decrement (prescaler modulus, ≥2)
- MAX_DIGITS, 3, keypad digits accepted per entry; further digits are ignored
- DONE_SECS, 2, whole seconds the done indicator stays high before returning to IDLE

Ports:
- clk  in  1  system clock
- clear  in  1  synchronous, active-high reset (one clock domain)
- key_valid  in  1  one-cycle pulse: key_digit is valid
- key_digit  in  4  BCD digit 0-9; values 10-15 are ignored
- startn  in  1  start request, active-low, level-sampled
- stopn  in  1  stop/cancel request, active-low, level-sampled
- door_closed  in  1  1 = door closed
- timer_zero  in  1  timer all-digits-zero flag
- timer_data  out  4  digit presented to timer data input
- timer_loadn  out  1  timer load strobe, active-low, one cycle per digit
- timer_en  out  1  timer count enable, one-cycle pulse per second
- timer_clearn  out  1  timer clear, active-low, one cycle
- mag_on  out  1  magnetron enable
- done  out  1  cook-complete indicator
- state_o  out  3  current FSM state encoding (debug/display)

Behaviour:
- Reset values, held while clear=1 and on the next edge after clear=1:
  - state IDLE
  - timer_loadn=1, timer_clearn=0 (timer cleared together with controller), timer_en=0
  - mag_on=0, done=0, timer_data=0
  - digit count=0, prescaler=0
- All outputs are registered: one-cycle latency from input sample to output.
- FSM states: IDLE=0, ENTRY=1, COOK=2, PAUSE=3, DONE=4.
- IDLE:
  - valid key (≤9) → present digit on timer_data, pulse timer_loadn=0 for one cycle, digit count=1, go to ENTRY.
  - startn=0 is ignored.
- ENTRY:
  - valid key with count<MAX_DIGITS → load pulse, count+1.
  - valid key with count=MAX_DIGITS → no pulse, no change.
  - startn=0 with door_closed=1 and timer_zero=0 → COOK, prescaler=0.
  - startn=0 with door_closed=0 or timer_zero=1 → stay in ENTRY.
  - stopn=0 → timer_clearn pulse, count=0, IDLE.
- COOK:
  - mag_on=1.
  - Prescaler counts 0..TICKS_PER_SEC-1; at the wrap it issues a timer_en pulse.
  - timer_zero=1 sampled in COOK → mag_on=0, DONE. No further timer_en pulse.
  - door_closed=0 or stopn=0 → PAUSE, mag_on=0 on the next cycle; prescaler holds its value.
  - Priority: timer_zero > door/stop.
- PAUSE:
  - startn=0 with door_closed=1 → COOK; prescaler resumes from its held value.
  - stopn=0 → clearn pulse, IDLE.
  - startn=0 and stopn=0 in the same cycle → stop wins.
- DONE:
  - done=1 for DONE_SECS×TICKS_PER_SEC cycles, then IDLE with count=0.
  - stopn=0 → immediate IDLE.
  - Keypad input is ignored.
- Keypad handling:
  - Key pulses outside IDLE/ENTRY are dropped.
  - Key pulse coincident with startn in ENTRY: start is taken and the key is dropped.
- Load and enable strobes: timer_loadn=0 and timer_en=1 are never asserted in the same cycle.
- Reset mid-cook: mag_on falls on the reset edge and the timer is cleared.

Decomposition:
- Shared package microondas_pkg holds:
  - state encodings (IDLE..DONE)
  - MAX_DIGITS default
  - BCD_MAX=9 constant
- One sub-module, prescaler_tick:
  - parameterised modulus
  - enable input, synchronous clear
  - one-cycle tick output, count held while disabled
- The FSM and output registers live in the top.

Test Plan:
1. Reset, then keys 1, 3, 0 → three timer_loadn pulses carrying data 1, 3, 0; state ENTRY. A 4th key 5 → no pulse.
2. After scenario 1, startn=0 with door closed → mag_on=1 one cycle later; timer_en pulses every 100 cycles (TICKS_PER_SEC=100); with a timer model loaded to 1:30, 90 pulses reach zero → DONE, done high for 200 cycles, then IDLE.
3. Cook 0:05; open the door at 250 cycles into cooking → PAUSE, mag_on=0, no timer_en. Close the door and start → the first tick arrives exactly 50 cycles later (prescaler held).
4. ENTRY with timer_zero=1 (all-zero digits) and startn=0 → stays in ENTRY, mag_on stays 0. startn=0 with door_closed=0 → no COOK.
5. PAUSE with startn=0 and stopn=0 in the same cycle → one timer_clearn pulse, IDLE, mag_on=0.
6. clear=1 asserted mid-COOK → next edge gives IDLE, mag_on=0, timer_clearn=0, done=0; keys accepted again after clear is deasserted.
